// File: rtl/wb_gpio_edge.sv
// Wishbone B3 GPIO slave: synchronised inputs, set/clear outputs, edge IRQs.
// Ports: wb_* bus slave, gpio_i pins in, gpio_o/gpio_dir_o pins out, irq_o level.
module wb_gpio_edge #(
    parameter int          GPIO_WIDTH     = 8,
    parameter logic [31:0] IRQ_RESET_MASK = 32'h0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [4:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);
    localparam int W = GPIO_WIDTH;

    logic [W-1:0] sync1, sync2, prev;
    logic [W-1:0] data_out, dir, irq_mask, irq_status, edge_sel;
    logic [W-1:0] wmask, wbits, w1c, edge_evt;
    logic [31:0]  lane_mask, wdata, rdata;
    logic [2:0]   idx;
    logic         txn, wr;
    logic         unused_bits;

    // The ack itself blocks a second transaction, so a held strobe
    // alternates ack / no-ack.
    assign txn = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr  = txn & wb_we_i;
    assign idx = wb_adr_i[4:2];

    assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                        {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wdata = wb_dat_i & lane_mask;
    assign wmask = lane_mask[W-1:0];
    assign wbits = wdata[W-1:0];

    assign w1c = (wr && idx == 3'd6) ? wbits : '0;

    assign edge_evt = (~edge_sel & sync2 & ~prev)
                    | ( edge_sel & ~sync2 & prev);

    assign unused_bits = ^{wb_adr_i[1:0], lane_mask, wdata};

    always_comb begin
        rdata = '0;
        unique case (idx)
            3'd0:    rdata[W-1:0] = sync2;
            3'd1:    rdata[W-1:0] = data_out;
            3'd2:    rdata[W-1:0] = dir;
            3'd5:    rdata[W-1:0] = irq_mask;
            3'd6:    rdata[W-1:0] = irq_status;
            3'd7:    rdata[W-1:0] = edge_sel;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            data_out   <= '0;
            dir        <= '0;
            irq_mask   <= IRQ_RESET_MASK[W-1:0];
            irq_status <= '0;
            edge_sel   <= '0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
        end else begin
            sync1    <= gpio_i;
            sync2    <= sync1;
            prev     <= sync2;
            wb_ack_o <= txn;
            wb_dat_o <= txn ? rdata : 32'h0;
            if (wr) begin
                case (idx)
                    3'd1:    data_out <= (data_out & ~wmask) | wbits;
                    3'd2:    dir      <= (dir & ~wmask) | wbits;
                    3'd3:    data_out <= data_out | wbits;
                    3'd4:    data_out <= data_out & ~wbits;
                    3'd5:    irq_mask <= (irq_mask & ~wmask) | wbits;
                    3'd7:    edge_sel <= (edge_sel & ~wmask) | wbits;
                    default: ;
                endcase
            end
            // A new edge beats a simultaneous write-1-to-clear.
            irq_status <= (irq_status & ~w1c) | edge_evt;
        end
    end

    assign gpio_o     = data_out;
    assign gpio_dir_o = dir;
    assign irq_o      = |(irq_status & irq_mask);

endmodule

// File: tb/tb_wb_gpio_edge.sv
// Self-checking bench for wb_gpio_edge (GPIO_WIDTH=32).
// Expected read data is queued at issue and popped when the ack arrives.
module tb_wb_gpio_edge;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [31:0] dat_o;
    logic        ack;
    logic [31:0] pins;
    logic [31:0] gpio_o, gpio_dir;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    wb_gpio_edge #(.GPIO_WIDTH(32), .IRQ_RESET_MASK(32'h0)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .gpio_i(pins), .gpio_o(gpio_o),
        .gpio_dir_o(gpio_dir), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: strobe, wait (bounded) for ack, drop strobe, one idle edge.
    task automatic wb_xfer(input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r, output int l);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        l = 99; r = '0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (ack === 1'b1) begin
                l = i; r = dat_o;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] r, e;
        int l;
        rst = 1; cyc = 1; stb = 1; we = 0; adr = 0; sel = 4'hF; dat = 0; pins = 0;
        step(); step();
        checks++;
        if ({ack, irq, gpio_o, gpio_dir, dat_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b irq=%b gpio=%h dir=%h dat=%h exp all 0",
                     ack, irq, gpio_o, gpio_dir, dat_o);
        end
        rst = 0; cyc = 0; stb = 0;
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h00, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL reset_data_in got=%h exp=%h", r, e); end
        checks++;
        if (l !== 1) begin failures++; $display("FAIL reset_ack_latency got=%0d exp=1", l); end
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h14, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL reset_irq_mask got=%h exp=%h", r, e); end
    endtask

    task automatic test_sync();
        logic [31:0] r, e;
        int l;
        pins = 32'h20;
        step();
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h00, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL sync_early got=%h exp=%h", r, e); end
        exp_q.push_back(32'h20);
        wb_xfer(0, 5'h00, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL sync_late got=%h exp=%h", r, e); end
        pins = 32'h60;
        exp_q.push_back(32'h20);
        wb_xfer(0, 5'h00, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL sync_1edge got=%h exp=%h", r, e); end
        exp_q.push_back(32'h60);
        wb_xfer(0, 5'h00, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL sync_2edge got=%h exp=%h", r, e); end
        exp_q.push_back(32'h60);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL sync_status got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h18, 32'h60, 4'b1110, r, l);
        exp_q.push_back(32'h60);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL w1c_lane_off got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h18, 32'h60, 4'hF, r, l);
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", r, e); end
    endtask

    task automatic test_out();
        logic [4:0]  a_t[4] = '{5'h04, 5'h08, 5'h0C, 5'h10};
        logic [31:0] d_t[4] = '{32'hA5, 32'hFF, 32'h02, 32'h81};
        logic [31:0] g_t[4] = '{32'hA5, 32'hA5, 32'hA7, 32'h26};
        logic [31:0] r, e;
        int l;
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1, a_t[i], d_t[i], 4'hF, r, l);
            checks++;
            if (gpio_o !== g_t[i]) begin
                failures++; $display("FAIL out_gpio[%0d] got=%h exp=%h", i, gpio_o, g_t[i]);
            end
            checks++;
            if (l !== 1) begin failures++; $display("FAIL out_latency[%0d] got=%0d exp=1", i, l); end
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL out_ack_width[%0d] got=%b exp=0", i, ack); end
        end
        checks++;
        if (gpio_dir !== 32'hFF) begin failures++; $display("FAIL out_dir got=%h exp=000000ff", gpio_dir); end
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h0C, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL out_set_reads0 got=%h exp=%h", r, e); end
        exp_q.push_back(32'h26);
        wb_xfer(0, 5'h04, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL out_readback got=%h exp=%h", r, e); end
    endtask

    task automatic test_lanes();
        logic [31:0] r, e;
        int l;
        wb_xfer(1, 5'h04, 32'h0, 4'hF, r, l);
        wb_xfer(1, 5'h04, 32'h12345678, 4'b0001, r, l);
        exp_q.push_back(32'h78);
        wb_xfer(0, 5'h04, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL lanes_0001 got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h04, 32'hAABBCCDD, 4'b1010, r, l);
        checks++;
        if (gpio_o !== 32'hAA00CC78) begin failures++; $display("FAIL lanes_1010 got=%h exp=aa00cc78", gpio_o); end
        wb_xfer(1, 5'h0C, 32'h00000101, 4'b0010, r, l);
        checks++;
        if (gpio_o !== 32'hAA00CD78) begin failures++; $display("FAIL lanes_set got=%h exp=aa00cd78", gpio_o); end
    endtask

    task automatic test_rising();
        logic [31:0] r, e;
        logic        ei[3] = '{1'b0, 1'b0, 1'b1};
        int l;
        wb_xfer(1, 5'h14, 32'h01, 4'hF, r, l);
        pins[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (irq !== ei[i]) begin failures++; $display("FAIL rise_irq_edge%0d got=%b exp=%b", i + 1, irq, ei[i]); end
        end
        exp_q.push_back(32'h01);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL rise_status got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h18, 32'h01, 4'hF, r, l);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rise_w1c_irq got=%b exp=0", irq); end
    endtask

    task automatic test_falling();
        logic [31:0] r, e;
        int l;
        wb_xfer(1, 5'h1C, 32'h08, 4'hF, r, l);
        wb_xfer(1, 5'h14, 32'h00, 4'hF, r, l);
        pins[3] = 1'b1;
        repeat (4) step();
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL fall_rise_ignored got=%h exp=%h", r, e); end
        pins[3] = 1'b0;
        repeat (3) step();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL fall_masked_irq got=%b exp=0", irq); end
        exp_q.push_back(32'h08);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL fall_status got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h14, 32'h08, 4'hF, r, l);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL fall_unmask_irq got=%b exp=1", irq); end
        wb_xfer(1, 5'h1C, 32'h09, 4'hF, r, l);
        step();
        exp_q.push_back(32'h08);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL edgesel_no_event got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h1C, 32'h08, 4'hF, r, l);
        wb_xfer(1, 5'h18, 32'h08, 4'hF, r, l);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL fall_w1c_irq got=%b exp=0", irq); end
    endtask

    task automatic test_collision();
        logic [31:0] r, e;
        int l;
        pins[0] = 1'b0;
        repeat (4) step();
        pins[0] = 1'b1;
        step(); step();
        wb_xfer(1, 5'h18, 32'h01, 4'hF, r, l);
        exp_q.push_back(32'h01);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL collision_set_wins got=%h exp=%h", r, e); end
        wb_xfer(1, 5'h18, 32'h01, 4'hF, r, l);
        exp_q.push_back(32'h0);
        wb_xfer(0, 5'h18, 0, 4'hF, r, l);
        e = exp_q.pop_front();
        checks++;
        if (r !== e) begin failures++; $display("FAIL collision_later_clear got=%h exp=%h", r, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        cyc = 1; stb = 1; we = 0; adr = 5'h04; sel = 4'hF;
        exp_q.push_back(32'hAA00CD78);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (ack !== ((i % 2) == 0)) begin
                failures++; $display("FAIL b2b_ack[%0d] got=%b exp=%b", i, ack, (i % 2) == 0);
            end
            if (ack === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (dat_o !== e) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, dat_o, e); end
                exp_q.push_back(32'hAA00CD78);
            end
        end
        cyc = 0; stb = 0;
        exp_q.delete();
        step();
    endtask

    initial begin
        test_reset();
        test_sync();
        test_out();
        test_lanes();
        test_rising();
        test_falling();
        test_collision();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
